seq_ones_counter: RTL and testbench

- Parametrised, iterative ones counter: counts the set bits of an N-bit word, K bits per clock, using a start/busy/done handshake.
- Generalises the team's fixed 7-input full-adder ones counter to arbitrary width.
- Adds a trade-off between area and latency through K.
- Adds a threshold compare output for majority and limit checks in downstream control logic.

---
 rtl/seq_ones_counter.sv | 119 +++++++++++
 tb/tb_seq_ones_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_ones_counter.sv
// Iterative ones counter: popcount of an N-bit word, K bits per clock, plus a threshold compare.
// Latency: done pulses N/K cycles after an accepted start; a new start is taken in the done cycle.
// Backpressure: start is ignored while busy; din/thr are sampled only on an accepted start.
module seq_ones_counter #(
  parameter int N  = 16,
  parameter int K  = 4,
  parameter int CW = $clog2(N + 1)  // derived; leave at default
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  din,
  input  logic [CW-1:0] thr,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          ge
);

  // Number of COUNT cycles, step counter width and per-step popcount width.
  localparam int STEPS = N / K;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW    = $clog2(K + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  shift_q;
  logic [N-1:0]  shift_d;
  logic [CW-1:0] thr_q;
  logic [SW-1:0] step_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          busy_q;
  logic          done_q;
  logic          ge_q;
  logic [PW-1:0] pop_d;
  logic          last_step;
  logic          accept;

  // Popcount of the K bits currently at the bottom of the shift register.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < K; i++) begin
      pop_d = pop_d + PW'(shift_q[i]);
    end
  end

  // Shift right by K with zero fill; with K == N the whole word is consumed in one step.
  if (K < N) begin : g_shift
    assign shift_d = {{K{1'b0}}, shift_q[N-1:K]};
  end else begin : g_noshift
    assign shift_d = '0;
  end

  // Accumulate; CW bits always hold N, and PW <= CW because K <= N.
  assign count_d   = count_q + CW'(pop_d);
  assign last_step = (step_q == SW'(STEPS - 1));
  assign accept    = start && (state_q != COUNT);

  // Control FSM with registered busy/done/count/ge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      thr_q   <= '0;
      step_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ge_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q <= COUNT;
            shift_q <= din;
            thr_q   <= thr;
            step_q  <= '0;
            count_q <= '0;
            ge_q    <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            // count and ge keep their final values until the next accept
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        COUNT: begin
          count_q <= count_d;
          shift_q <= shift_d;
          step_q  <= step_q + 1'b1;
          if (last_step) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ge_q    <= (count_d >= thr_q);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;
  assign ge    = ge_q;

endmodule

// File: tb/tb_seq_ones_counter.sv
// Randomized bench for seq_ones_counter in three shapes: N16/K4, N7/K1 and N8/K8.
// Expected count is the plain popcount of the word captured at accept; ge is count >= thr.
module tb_seq_ones_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT a: N=16, K=4
  logic        a_start = 1'b0;
  logic [15:0] a_din = '0;
  logic [4:0]  a_thr = '0;
  logic        a_busy, a_done, a_ge;
  logic [4:0]  a_count;
  // DUT b: N=7, K=1
  logic        b_start = 1'b0;
  logic [6:0]  b_din = '0;
  logic [2:0]  b_thr = '0;
  logic        b_busy, b_done, b_ge;
  logic [2:0]  b_count;
  // DUT c: N=8, K=8
  logic        c_start = 1'b0;
  logic [7:0]  c_din = '0;
  logic [3:0]  c_thr = '0;
  logic        c_busy, c_done, c_ge;
  logic [3:0]  c_count;

  seq_ones_counter #(.N(16), .K(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .din(a_din), .thr(a_thr),
    .busy(a_busy), .done(a_done), .count(a_count), .ge(a_ge));
  seq_ones_counter #(.N(7), .K(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .din(b_din), .thr(b_thr),
    .busy(b_busy), .done(b_done), .count(b_count), .ge(b_ge));
  seq_ones_counter #(.N(8), .K(8)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .din(c_din), .thr(c_thr),
    .busy(c_busy), .done(c_done), .count(c_count), .ge(c_ge));

  int total = 0;
  int bad = 0;
  int sel = 0;
  int last_cnt = 0;
  bit last_ge = 1'b0;

  logic       cur_busy, cur_done, cur_ge;
  logic [4:0] cur_count;

  // Observe whichever DUT is currently under test.
  always_comb begin
    cur_busy = a_busy; cur_done = a_done; cur_ge = a_ge; cur_count = a_count;
    case (sel)
      1: begin cur_busy = b_busy; cur_done = b_done; cur_ge = b_ge; cur_count = 5'(b_count); end
      2: begin cur_busy = c_busy; cur_done = c_done; cur_ge = c_ge; cur_count = 5'(c_count); end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [15:0] d, input logic [4:0] t);
    case (w)
      0: begin a_start = s; a_din = d;      a_thr = t;      end
      1: begin b_start = s; b_din = d[6:0]; b_thr = t[2:0]; end
      default: begin c_start = s; c_din = d[7:0]; c_thr = t[3:0]; end
    endcase
  endtask

  // One operation: accept on the next edge, then follow it cycle by cycle up to the done pulse.
  // Called right after a done check, the accept lands in the DONE cycle (back-to-back).
  task automatic op(input int w, input logic [15:0] d, input logic [4:0] t, input bit hold);
    int n, steps, cw, exp_cnt, tm;
    bit exp_ge;
    case (w)
      0: begin n = 16; steps = 4; cw = 5; end
      1: begin n = 7;  steps = 7; cw = 3; end
      default: begin n = 8; steps = 1; cw = 4; end
    endcase
    exp_cnt = $countones(int'(d) & ((1 << n) - 1));
    tm = int'(t) & ((1 << cw) - 1);
    exp_ge = (exp_cnt >= tm);
    sel = w;
    drive(w, 1'b1, d, t);
    for (int c = 0; c <= steps; c++) begin
      @(posedge clk); #1;
      if (c < steps) begin
        chk("busy_run", 32'(cur_busy), 32'd1);
        chk("done_run", 32'(cur_done), 32'd0);
        if (c == 0) begin
          chk("count_clr", 32'(cur_count), 32'd0);
          chk("ge_clr", 32'(cur_ge), 32'd0);
        end
        // start/din/thr churn while busy must be ignored
        drive(w, hold ? 1'b1 : 1'($urandom), 16'($urandom), 5'($urandom));
      end else begin
        chk("done_pulse", 32'(cur_done), 32'd1);
        chk("busy_done", 32'(cur_busy), 32'd0);
        chk("count", 32'(cur_count), 32'(exp_cnt));
        chk("ge", 32'(cur_ge), 32'(exp_ge));
        drive(w, 1'b0, 16'($urandom), 5'($urandom));
      end
    end
    last_cnt = exp_cnt;
    last_ge = exp_ge;
  endtask

  // Idle cycles after an operation: done low, not busy, results held.
  task automatic idle(input int w, input int cycles);
    sel = w;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      chk("idle_done", 32'(cur_done), 32'd0);
      chk("idle_busy", 32'(cur_busy), 32'd0);
      chk("hold_count", 32'(cur_count), 32'(last_cnt));
      chk("hold_ge", 32'(cur_ge), 32'(last_ge));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values on all three shapes
    #2;
    for (int w = 0; w < 3; w++) begin
      sel = w; #1;
      chk("rst_busy", 32'(cur_busy), 32'd0);
      chk("rst_done", 32'(cur_done), 32'd0);
      chk("rst_count", 32'(cur_count), 32'd0);
      chk("rst_ge", 32'(cur_ge), 32'd0);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // directed N16/K4 cases
    op(0, 16'hFFFF, 5'd16, 1'b0); idle(0, 2);
    op(0, 16'hA5C3, 5'd9, 1'b0);  idle(0, 1);
    op(0, 16'hA5C3, 5'd8, 1'b0);  idle(0, 1);
    op(0, 16'h0000, 5'd0, 1'b0);  idle(0, 1);

    // start held high throughout; second accept happens in the DONE cycle
    op(0, 16'($urandom), 5'($urandom_range(0, 16)), 1'b1);
    op(0, 16'($urandom), 5'($urandom_range(0, 16)), 1'b1);
    idle(0, 3);

    // reset in the middle of COUNT
    sel = 0;
    drive(0, 1'b1, 16'hFFFF, 5'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 5'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("arst_busy", 32'(cur_busy), 32'd0);
    chk("arst_done", 32'(cur_done), 32'd0);
    chk("arst_count", 32'(cur_count), 32'd0);
    chk("arst_ge", 32'(cur_ge), 32'd0);
    @(negedge clk); rst = 1'b0;
    last_cnt = 0; last_ge = 1'b0;
    idle(0, 6);
    op(0, 16'h0001, 5'd1, 1'b0); idle(0, 1);

    // random N16/K4 traffic with random gaps and back-to-back runs
    for (int i = 0; i < 20; i++) begin
      op(0, 16'($urandom), 5'($urandom_range(0, 17)), 1'($urandom));
      if ($urandom_range(0, 2) != 0) idle(0, $urandom_range(1, 3));
    end
    idle(0, 1);

    // N7/K1: directed vector then sweep of every input
    op(1, 16'b1011011, 5'd4, 1'b0); idle(1, 1);
    for (int v = 0; v < 128; v++) begin
      op(1, 16'(v), 5'($urandom_range(0, 7)), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1, 1);
    end
    idle(1, 1);

    // N8/K8: single-cycle count and result hold
    op(2, 16'h007E, 5'($urandom_range(0, 8)), 1'b0);
    idle(2, 5);
    for (int i = 0; i < 10; i++) begin
      op(2, 16'($urandom), 5'($urandom_range(0, 9)), 1'($urandom));
      if ($urandom_range(0, 1) != 0) idle(2, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
